alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter_pkg.sv | 44 ++++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing block: data width,
// ALU control encoding, operation/response records and slot helpers.
package alu_share_arbiter_pkg;

   localparam int DATA_W  = 32;
   localparam int CTRL_W  = 4;
   localparam int NUM_REQ = 2;

   // Control codes understood by the shared combinational ALU
   typedef enum logic [CTRL_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_ctrl_e;

   // One operation as presented by a requester
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [CTRL_W-1:0] ctrl;
   } alu_op_t;

   // One captured ALU response
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
   } alu_rsp_t;

   localparam alu_op_t  ALU_OP_IDLE  = '0;
   localparam alu_rsp_t ALU_RSP_NONE = '0;

   // A 1-deep slot can take a new result when empty or being drained now
   function automatic logic slot_free(input logic vld, input logic rdy);
      return (!vld) || rdy;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter. Grant is combinational from eligibility; a one-bit
// last_grant pointer gives round-robin fairness unless FIXED_PRIO is set,
// in which case requester 0 always wins a contest.
module rr_arbiter2
   import alu_share_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   logic last_grant;
   logic prefer_req0;

   // Requester 0 wins a contest in fixed mode, or when requester 1 won last
   assign prefer_req0 = FIXED_PRIO || last_grant;

   // Grant at most one eligible requester
   always_comb begin
      grant = 2'b00;
      unique case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prefer_req0 ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer moves only on an accepted grant; reset favours requester 0 first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. Each requester owns a
// 1-deep response slot; a requester may only be granted when its slot is
// free, so an accepted operation always has somewhere to land one cycle later.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,

   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,

   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,

   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   // ---- p0: request side, arbitration and ALU operand mux ----
   logic [NUM_REQ-1:0] req_vld_p0;
   logic [NUM_REQ-1:0] rsp_rdy_p0;
   logic [NUM_REQ-1:0] slot_free_p0;
   logic [NUM_REQ-1:0] elig_p0;
   logic [NUM_REQ-1:0] grant_p0;
   alu_op_t            req_op_p0 [NUM_REQ];
   alu_op_t            alu_op_p0;
   alu_rsp_t           alu_rsp_p0;
   logic               run_en;

   // ---- p1: registered response slots ----
   logic [NUM_REQ-1:0] vld_p1;
   alu_rsp_t           slot_p1 [NUM_REQ];

   assign req_vld_p0 = {req1_valid, req0_valid};
   assign rsp_rdy_p0 = {rsp1_ready, rsp0_ready};
   assign req_op_p0[0] = '{a: req0_a, b: req0_b, ctrl: req0_ctrl};
   assign req_op_p0[1] = '{a: req1_a, b: req1_b, ctrl: req1_ctrl};

   // Arbitration is held off until the first clock edge after reset release,
   // so nothing is accepted while rst_n is low or on the release edge itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en <= 1'b0;
      end else begin
         run_en <= 1'b1;
      end
   end

   // Eligibility: valid request whose response slot can accept a result
   always_comb begin
      for (int n = 0; n < NUM_REQ; n++) begin
         slot_free_p0[n] = slot_free(vld_p1[n], rsp_rdy_p0[n]);
         elig_p0[n]      = run_en && req_vld_p0[n] && slot_free_p0[n];
      end
   end

   rr_arbiter2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .elig  (elig_p0),
      .grant (grant_p0)
   );

   assign req0_ready = grant_p0[0];
   assign req1_ready = grant_p0[1];

   // Steer the granted requester's operation to the shared ALU; idle drives 0
   always_comb begin
      alu_op_p0 = ALU_OP_IDLE;
      if (grant_p0[0]) begin
         alu_op_p0 = req_op_p0[0];
      end else if (grant_p0[1]) begin
         alu_op_p0 = req_op_p0[1];
      end
   end

   assign alu_a      = alu_op_p0.a;
   assign alu_b      = alu_op_p0.b;
   assign alu_ctrl   = alu_op_p0.ctrl;
   assign alu_rsp_p0 = '{result: alu_result, zero: alu_zero};

   // ---- p0 -> p1: response slot capture ----
   for (genvar n = 0; n < NUM_REQ; n++) begin : g_slot
      // Load on grant (refill wins over drain), clear valid on drain only,
      // otherwise hold; result/zero keep their last value after a drain
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p1[n]  <= 1'b0;
            slot_p1[n] <= ALU_RSP_NONE;
         end else if (grant_p0[n]) begin
            vld_p1[n]  <= 1'b1;
            slot_p1[n] <= alu_rsp_p0;
         end else if (rsp_rdy_p0[n]) begin
            vld_p1[n]  <= 1'b0;
         end
      end
   end

   assign rsp0_valid  = vld_p1[0];
   assign rsp0_result = slot_p1[0].result;
   assign rsp0_zero   = slot_p1[0].zero;
   assign rsp1_valid  = vld_p1[1];
   assign rsp1_result = slot_p1[1].result;
   assign rsp1_zero   = slot_p1[1].zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance (a_*) and a fixed-priority instance
// (b_*) sharing clock and reset, each driving its own ALU model.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   // Round-robin instance signals
   logic        a_req0_valid = 0, a_req1_valid = 0, a_req0_ready, a_req1_ready;
   logic [31:0] a_req0_a = 0, a_req0_b = 0, a_req1_a = 0, a_req1_b = 0;
   logic [3:0]  a_req0_ctrl = 0, a_req1_ctrl = 0;
   logic        a_rsp0_valid, a_rsp1_valid, a_rsp0_zero, a_rsp1_zero;
   logic        a_rsp0_ready = 1, a_rsp1_ready = 1;
   logic [31:0] a_rsp0_result, a_rsp1_result;
   logic [31:0] a_alu_a, a_alu_b, a_alu_result;
   logic [3:0]  a_alu_ctrl;
   logic        a_alu_zero;

   // Fixed-priority instance signals
   logic        b_req0_valid = 0, b_req1_valid = 0, b_req0_ready, b_req1_ready;
   logic [31:0] b_req0_a = 0, b_req0_b = 0, b_req1_a = 0, b_req1_b = 0;
   logic [3:0]  b_req0_ctrl = 0, b_req1_ctrl = 0;
   logic        b_rsp0_valid, b_rsp1_valid, b_rsp0_zero, b_rsp1_zero;
   logic        b_rsp0_ready = 1, b_rsp1_ready = 1;
   logic [31:0] b_rsp0_result, b_rsp1_result;
   logic [31:0] b_alu_a, b_alu_b, b_alu_result;
   logic [3:0]  b_alu_ctrl;
   logic        b_alu_zero;

   function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic [3:0] c);
      case (c)
         4'b0000: return x + y;
         4'b0001: return x - y;
         4'b0010: return x << y[4:0];
         4'b0011: return {31'd0, $signed(x) < $signed(y)};
         4'b0100: return {31'd0, x < y};
         4'b0101: return x ^ y;
         4'b0110: return x >> y[4:0];
         4'b0111: return $unsigned($signed(x) >>> y[4:0]);
         4'b1000: return x | y;
         4'b1001: return x & y;
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      a_alu_result = alu_model(a_alu_a, a_alu_b, a_alu_ctrl);
      a_alu_zero   = (a_alu_result == 32'd0);
      b_alu_result = alu_model(b_alu_a, b_alu_b, b_alu_ctrl);
      b_alu_zero   = (b_alu_result == 32'd0);
   end

   alu_share_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_a(a_req0_a),
      .req0_b(a_req0_b), .req0_ctrl(a_req0_ctrl),
      .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_a(a_req1_a),
      .req1_b(a_req1_b), .req1_ctrl(a_req1_ctrl),
      .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready), .rsp0_result(a_rsp0_result),
      .rsp0_zero(a_rsp0_zero),
      .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready), .rsp1_result(a_rsp1_result),
      .rsp1_zero(a_rsp1_zero),
      .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_ctrl(a_alu_ctrl),
      .alu_result(a_alu_result), .alu_zero(a_alu_zero)
   );

   alu_share_arbiter #(.FIXED_PRIO(1'b1)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a),
      .req0_b(b_req0_b), .req0_ctrl(b_req0_ctrl),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a),
      .req1_b(b_req1_b), .req1_ctrl(b_req1_ctrl),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_result(b_rsp0_result),
      .rsp0_zero(b_rsp0_zero),
      .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_result(b_rsp1_result),
      .rsp1_zero(b_rsp1_zero),
      .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_ctrl(b_alu_ctrl),
      .alu_result(b_alu_result), .alu_zero(b_alu_zero)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with a request pending: nothing may be accepted
      a_req0_valid = 1; a_req0_a = 32'd1; a_req0_b = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_req0_ready", a_req0_ready, 1'b0);
      chk1("rst_rsp0_valid", a_rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", a_rsp1_valid, 1'b0);
      chk32("rst_rsp0_result", a_rsp0_result, 32'd0);
      chk1("rst_rsp0_zero", a_rsp0_zero, 1'b0);
      chk32("rst_alu_a", a_alu_a, 32'd0);
      @(negedge clk);
      a_req0_valid = 0;
      rst_n = 1;
      @(posedge clk);

      // Both saturated, both drained every cycle: grants 0,1,0,1
      @(negedge clk);
      a_req0_valid = 1; a_req0_a = 32'd7;    a_req0_b = 32'd7;    a_req0_ctrl = 4'b0001;
      a_req1_valid = 1; a_req1_a = 32'hF0;   a_req1_b = 32'h0F;   a_req1_ctrl = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk1($sformatf("alt%0d_req0_ready", k), a_req0_ready, (k % 2) == 0);
         chk1($sformatf("alt%0d_req1_ready", k), a_req1_ready, (k % 2) == 1);
         chk32($sformatf("alt%0d_alu_a", k), a_alu_a, ((k % 2) == 0) ? 32'd7 : 32'hF0);
         @(posedge clk); #1;
         if ((k % 2) == 0) begin
            chk1($sformatf("alt%0d_rsp0_valid", k), a_rsp0_valid, 1'b1);
            chk32($sformatf("alt%0d_rsp0_result", k), a_rsp0_result, 32'd0);
            chk1($sformatf("alt%0d_rsp0_zero", k), a_rsp0_zero, 1'b1);
         end else begin
            chk1($sformatf("alt%0d_rsp1_valid", k), a_rsp1_valid, 1'b1);
            chk32($sformatf("alt%0d_rsp1_result", k), a_rsp1_result, 32'hFF);
            chk1($sformatf("alt%0d_rsp1_zero", k), a_rsp1_zero, 1'b0);
         end
      end
      @(negedge clk);
      a_req0_valid = 0; a_req1_valid = 0;
      #1;
      chk32("idle_alu_a", a_alu_a, 32'd0);
      chk32("idle_alu_ctrl", {28'd0, a_alu_ctrl}, 32'd0);
      @(posedge clk); #1;
      chk1("drain_rsp1_valid", a_rsp1_valid, 1'b0);
      chk32("drain_rsp1_hold", a_rsp1_result, 32'hFF);

      // Single requester 0: 5 + 3, accepted same cycle, result next cycle
      @(negedge clk);
      a_req0_valid = 1; a_req0_a = 32'd5; a_req0_b = 32'd3; a_req0_ctrl = 4'b0000;
      #1;
      chk1("single_req0_ready", a_req0_ready, 1'b1);
      chk1("single_req1_ready", a_req1_ready, 1'b0);
      @(posedge clk); #1;
      chk1("single_rsp0_valid", a_rsp0_valid, 1'b1);
      chk32("single_rsp0_result", a_rsp0_result, 32'd8);
      chk1("single_rsp0_zero", a_rsp0_zero, 1'b0);
      @(negedge clk);
      a_req0_valid = 0;
      @(posedge clk); #1;
      chk1("single_drain_valid", a_rsp0_valid, 1'b0);
      chk32("single_drain_hold", a_rsp0_result, 32'd8);

      // Slot 0 stalled: requester 1 takes every cycle, slot 0 holds
      @(negedge clk);
      a_rsp0_ready = 0;
      a_req0_valid = 1; a_req0_a = 32'd2; a_req0_b = 32'd2; a_req0_ctrl = 4'b0000;
      @(posedge clk); #1;
      chk32("stall_load_result", a_rsp0_result, 32'd4);
      @(negedge clk);
      a_req0_a = 32'd9; a_req0_b = 32'd9;
      a_req1_valid = 1; a_req1_a = 32'd10; a_req1_b = 32'd20; a_req1_ctrl = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk1($sformatf("stall%0d_req0_ready", k), a_req0_ready, 1'b0);
         chk1($sformatf("stall%0d_req1_ready", k), a_req1_ready, 1'b1);
         @(posedge clk); #1;
         chk1($sformatf("stall%0d_rsp0_valid", k), a_rsp0_valid, 1'b1);
         chk32($sformatf("stall%0d_rsp0_result", k), a_rsp0_result, 32'd4);
         chk32($sformatf("stall%0d_rsp1_result", k), a_rsp1_result, 32'd30);
      end

      // Drain and refill slot 0 in one cycle: 1 + 1, no bubble
      @(negedge clk);
      a_req1_valid = 0;
      a_rsp0_ready = 1;
      a_req0_a = 32'd1; a_req0_b = 32'd1; a_req0_ctrl = 4'b0000;
      #1;
      chk1("refill_req0_ready", a_req0_ready, 1'b1);
      @(posedge clk); #1;
      chk1("refill_rsp0_valid", a_rsp0_valid, 1'b1);
      chk32("refill_rsp0_result", a_rsp0_result, 32'd2);

      // Hold a result in slot 1, then assert reset mid-cycle
      @(negedge clk);
      a_req0_valid = 0;
      a_rsp1_ready = 0;
      a_req1_valid = 1; a_req1_a = 32'd3; a_req1_b = 32'd4; a_req1_ctrl = 4'b0000;
      @(posedge clk); #1;
      chk1("prerst_rsp1_valid", a_rsp1_valid, 1'b1);
      chk32("prerst_rsp1_result", a_rsp1_result, 32'd7);
      @(negedge clk);
      a_req1_valid = 0;
      #2;
      rst_n = 0;
      #1;
      chk1("async_rst_rsp1_valid", a_rsp1_valid, 1'b0);
      chk32("async_rst_rsp1_result", a_rsp1_result, 32'd0);
      a_rsp1_ready = 1;
      a_req0_valid = 1; a_req0_a = 32'd5;   a_req0_b = 32'd3;   a_req0_ctrl = 4'b0000;
      a_req1_valid = 1; a_req1_a = 32'hFF;  a_req1_b = 32'h0F;  a_req1_ctrl = 4'b1001;
      #1;
      chk1("in_rst_req0_ready", a_req0_ready, 1'b0);
      chk1("in_rst_req1_ready", a_req1_ready, 1'b0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      @(negedge clk); #1;
      chk1("post_rst_req0_first", a_req0_ready, 1'b1);
      chk1("post_rst_req1_wait", a_req1_ready, 1'b0);
      @(posedge clk); #1;
      chk32("post_rst_rsp0_result", a_rsp0_result, 32'd8);
      @(negedge clk); #1;
      chk1("post_rst_req1_second", a_req1_ready, 1'b1);
      @(posedge clk); #1;
      chk32("post_rst_rsp1_and", a_rsp1_result, 32'h0F);
      chk1("post_rst_rsp1_zero", a_rsp1_zero, 1'b0);
      @(negedge clk);
      a_req0_valid = 0; a_req1_valid = 0;

      // Fixed priority: requester 0 wins for 4 cycles, then requester 1
      b_req0_valid = 1; b_req0_a = 32'd1; b_req0_b = 32'd1; b_req0_ctrl = 4'b0000;
      b_req1_valid = 1; b_req1_a = 32'd2; b_req1_b = 32'd2; b_req1_ctrl = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk1($sformatf("fix%0d_req0_ready", k), b_req0_ready, 1'b1);
         chk1($sformatf("fix%0d_req1_ready", k), b_req1_ready, 1'b0);
         @(posedge clk); #1;
         chk32($sformatf("fix%0d_rsp0_result", k), b_rsp0_result, 32'd2);
      end
      @(negedge clk);
      b_req0_valid = 0;
      #1;
      chk1("fix_after_req1_ready", b_req1_ready, 1'b1);
      @(posedge clk); #1;
      chk1("fix_after_rsp1_valid", b_rsp1_valid, 1'b1);
      chk32("fix_after_rsp1_result", b_rsp1_result, 32'd4);
      @(negedge clk);
      b_req1_valid = 0;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
